// File: rtl/stage_3combind_pkg.sv
// Shared constants for the three-stage two-phase micropipeline.
// Default data width and the fixed stage count.
package stage_3combind_pkg;

    localparam int DEF_WIDTH = 3;
    localparam int STAGES    = 3;

endpackage

// File: rtl/stage_3combind_if.sv
// Two-phase req/ack bus around the pipeline.
// slave is the pipeline side, master the producer/consumer side.
interface stage_3combind_if
    import stage_3combind_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             req_in;
    logic [WIDTH-1:0] data_in;
    logic             ack_out;
    logic             req_out;
    logic [WIDTH-1:0] data_out;
    logic             ack_in;

    modport slave (
        input  req_in,
        input  data_in,
        input  ack_in,
        output ack_out,
        output req_out,
        output data_out
    );

    modport master (
        output req_in,
        output data_in,
        output ack_in,
        input  ack_out,
        input  req_out,
        input  data_out
    );

endinterface

// File: rtl/stage_3combind_stage_cell.sv
// One micropipeline stage: phase bit plus data token.
// Fires when upstream offers a new phase and downstream has consumed ours.
module stage_cell #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r_prev,
    input  logic             a_next,
    input  logic [WIDTH-1:0] d_prev,
    output logic             p,
    output logic [WIDTH-1:0] d
);

    logic fire;

    assign fire = (r_prev != p) && (a_next == p);

    // Toggle phase and capture the upstream token on fire.
    always_ff @(posedge clk) begin
        if (!rst) begin
            p <= 1'b0;
            d <= '0;
        end else if (fire) begin
            p <= ~p;
            d <= d_prev;
        end
    end

endmodule

// File: rtl/stage_3combind.sv
// Three-deep two-phase elastic pipeline built from a chain of stage_cell.
// All outputs come straight from stage registers.
module stage_3combind
    import stage_3combind_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    stage_3combind_if.slave  bus
);

    logic [STAGES-1:0] p;
    logic [STAGES-1:0] r;
    logic [STAGES-1:0] a;
    logic [WIDTH-1:0]  d [STAGES+1];

    // Stage k sees the previous phase as request, the next phase as ack.
    assign r    = {p[STAGES-2:0], bus.req_in};
    assign a    = {bus.ack_in, p[STAGES-1:1]};
    assign d[0] = bus.data_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .r_prev (r[k]),
            .a_next (a[k]),
            .d_prev (d[k]),
            .p      (p[k]),
            .d      (d[k+1])
        );
    end

    assign bus.ack_out  = p[0];
    assign bus.req_out  = p[STAGES-1];
    assign bus.data_out = d[STAGES];

endmodule

// File: tb/tb_stage_3combind.sv
// Directed bench for the three-stage two-phase pipeline.
// Expected tokens and phases are hand-derived.
module tb_stage_3combind;
    import stage_3combind_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    stage_3combind_if #(.WIDTH(DEF_WIDTH)) bus();

    stage_3combind #(
        .WIDTH (DEF_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass = 0;
    int n_chk  = 0;
    logic [2:0] tx [4];
    int tx_i;
    int rx;
    int tog;
    logic prev;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [2:0] v);
        bus.req_in  = ~bus.req_in;
        bus.data_in = v;
        for (int i = 0; i < 20 && bus.ack_out != bus.req_in; i++) step();
        chk(tag, bus.ack_out == bus.req_in, 1);
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && bus.req_out == bus.ack_in; i++) step();
        chk(tag, bus.req_out != bus.ack_in, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        bus.req_in  = 1'b0;
        bus.ack_in  = 1'b0;
        bus.data_in = '0;
        step();
        step();
        chk("rst_req", bus.req_out, 0);
        chk("rst_ack", bus.ack_out, 0);
        chk("rst_data", bus.data_out, 0);

        rst = 1'b1;
        step();
        bus.req_in  = 1'b1;
        bus.data_in = 3'd1;
        step();
        chk("t2_ack", bus.ack_out, 1);
        chk("t2_req_n0", bus.req_out, 0);
        step();
        chk("t2_req_n1", bus.req_out, 0);
        step();
        chk("t2_req_n2", bus.req_out, 1);
        chk("t2_data", bus.data_out, 1);
        bus.ack_in = 1'b1;
        step();
        step();
        chk("t2_hold_req", bus.req_out, 1);
        chk("t2_hold_ack", bus.ack_out, 1);
        chk("t2_hold_data", bus.data_out, 1);

        tx = '{3'd1, 3'd2, 3'd3, 3'd4};
        tx_i = 0;
        rx = 0;
        for (int c = 0; c < 60 && rx < 4; c++) begin
            if (tx_i < 4 && bus.ack_out == bus.req_in) begin
                bus.req_in  = ~bus.req_in;
                bus.data_in = tx[tx_i];
                tx_i++;
            end
            if (bus.req_out != bus.ack_in) begin
                chk("stream_d", bus.data_out, tx[rx]);
                rx++;
                bus.ack_in = ~bus.ack_in;
            end
            step();
        end
        chk("stream_n", rx, 4);
        for (int i = 0; i < 4; i++) step();
        chk("stream_nodup", bus.req_out != bus.ack_in, 0);
        chk("stream_acc", bus.ack_out == bus.req_in, 1);

        tx = '{3'd5, 3'd6, 3'd7, 3'd0};
        tx_i = 0;
        tog = 0;
        for (int c = 0; c < 20; c++) begin
            prev = bus.ack_out;
            if (tx_i < 4 && bus.ack_out == bus.req_in) begin
                bus.req_in  = ~bus.req_in;
                bus.data_in = tx[tx_i];
                tx_i++;
            end
            step();
            if (bus.ack_out != prev) tog++;
        end
        chk("bp_toggles", tog, 3);
        chk("bp_data", bus.data_out, 5);
        chk("bp_pending", bus.ack_out != bus.req_in, 1);
        chk("bp_req", bus.req_out != bus.ack_in, 1);
        bus.ack_in = ~bus.ack_in;
        wait_req("bp_w6");
        chk("bp_d6", bus.data_out, 6);
        bus.ack_in = ~bus.ack_in;
        wait_req("bp_w7");
        chk("bp_d7", bus.data_out, 7);
        bus.ack_in = ~bus.ack_in;
        wait_req("bp_w0");
        chk("bp_d0", bus.data_out, 0);
        chk("bp_acc", bus.ack_out == bus.req_in, 1);
        bus.ack_in = ~bus.ack_in;
        step();
        step();

        push("t5_a", 3'd1);
        push("t5_b", 3'd2);
        rst         = 1'b0;
        bus.req_in  = 1'b0;
        bus.ack_in  = 1'b0;
        bus.data_in = '0;
        step();
        chk("t5_rst_req", bus.req_out, 0);
        chk("t5_rst_ack", bus.ack_out, 0);
        chk("t5_rst_data", bus.data_out, 0);
        rst = 1'b1;
        step();
        push("t5_c", 3'd3);
        wait_req("t5_w");
        chk("t5_d", bus.data_out, 3);
        bus.ack_in = 1'b1;
        step();
        step();

        bus.ack_in = 1'b0;
        step();
        step();
        step();
        chk("t6_req", bus.req_out, 1);
        chk("t6_data", bus.data_out, 3);
        chk("t6_ack", bus.ack_out, 1);
        bus.ack_in = 1'b1;
        step();
        step();
        chk("t6_req2", bus.req_out, 1);
        chk("t6_data2", bus.data_out, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
